lock_input_cond: RTL and testbench

//   Front-end conditioner for the lock FSM on the Arty A7-35T board.
//   - Synchronises raw board buttons/switches to clk and debounces them.
//   - Converts the ENTER and OOPS buttons into single-cycle pulses.
//   - Drives the lock FSM inputs: onoff, oops, enter, login[3:0].

---
 rtl/lock_pkg.sv | 31 +++
 rtl/lock_debounce.sv | 65 ++++++
 rtl/lock_input_cond.sv | 136 +++++++++++++
 tb/tb_lock_input_cond.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock front-end: button FSM encoding, the default
// debounce length and a constant-evaluable ceiling log2.
package lock_pkg;

    localparam logic [1:0] BTN_ST_IDLE         = 2'd0;
    localparam logic [1:0] BTN_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] BTN_ST_HELD         = 2'd2;
    localparam logic [1:0] BTN_ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        BTN_IDLE         = BTN_ST_IDLE,
        BTN_PRESS_WAIT   = BTN_ST_PRESS_WAIT,
        BTN_HELD         = BTN_ST_HELD,
        BTN_RELEASE_WAIT = BTN_ST_RELEASE_WAIT
    } btn_state_e;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lock_debounce.sv
// Per-input synchroniser and debounce counter; exposes the synchronised sample
// and the accepted (debounced) level.
module lock_debounce
    import lock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic synced_o,
    output logic level_o
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];

    // synchroniser shift chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // count consecutive samples that disagree with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = synced_s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // counter and accepted-level registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign synced_o = synced_s;
    assign level_o  = level_q;

endmodule

// File: rtl/lock_input_cond.sv
// Lock FSM input conditioner: debounced levels plus one-pulse-per-press buttons.
// Optional LOCK_LOGIN_LATCH_EN: login is captured on each enter pulse.
module lock_input_cond
    import lock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int N_SW            = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_enter,
    input  logic            btn_oops,
    input  logic            sw_onoff,
    input  logic [N_SW-1:0] sw_login,
    output logic            enter,
    output logic            oops,
    output logic            onoff,
    output logic [N_SW-1:0] login
);

    // bit 0 enter, bit 1 oops, bit 2 onoff, bits 3.. login
    localparam int N_IN = N_SW + 3;

    logic [N_IN-1:0] raw_s;
    logic [N_IN-1:0] synced_s;
    logic [N_IN-1:0] level_s;
    logic [N_IN-3:0] unused_synced_s;
    logic [1:0]      press_s;

    assign raw_s           = {sw_login, sw_onoff, btn_oops, btn_enter};
    assign unused_synced_s = synced_s[N_IN-1:2];

    for (genvar g = 0; g < N_IN; g++) begin : g_db
        lock_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (raw_s[g]),
            .synced_o (synced_s[g]),
            .level_o  (level_s[g])
        );
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        btn_state_e state_q;
        btn_state_e state_d;
        logic       press_l;

        // button state register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= BTN_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // press is flagged only on the accepted rise, so holding never repeats
        always_comb begin
            state_d = state_q;
            press_l = 1'b0;
            case (state_q)
                BTN_IDLE: begin
                    if (synced_s[b]) state_d = BTN_PRESS_WAIT;
                    else             state_d = BTN_IDLE;
                end
                BTN_PRESS_WAIT: begin
                    if (level_s[b]) begin
                        state_d = BTN_HELD;
                        press_l = 1'b1;
                    end else if (!synced_s[b]) begin
                        state_d = BTN_IDLE;
                    end else begin
                        state_d = BTN_PRESS_WAIT;
                    end
                end
                BTN_HELD: begin
                    if (!synced_s[b]) state_d = BTN_RELEASE_WAIT;
                    else              state_d = BTN_HELD;
                end
                BTN_RELEASE_WAIT: begin
                    if (!level_s[b])     state_d = BTN_IDLE;
                    else if (synced_s[b]) state_d = BTN_HELD;
                    else                  state_d = BTN_RELEASE_WAIT;
                end
                default: begin
                    state_d = BTN_IDLE;
                end
            endcase
        end

        assign press_s[b] = press_l;
    end

    logic            enter_q, enter_d;
    logic            oops_q,  oops_d;
    logic            onoff_q, onoff_d;
    logic [N_SW-1:0] login_q, login_d;

    // output next-state: oops wins a same-cycle tie with enter
    always_comb begin
        enter_d = press_s[0] & ~press_s[1];
        oops_d  = press_s[1];
        onoff_d = level_s[2];
`ifdef LOCK_LOGIN_LATCH_EN
        if (enter_d) login_d = level_s[N_IN-1:3];
        else         login_d = login_q;
`else
        login_d = level_s[N_IN-1:3];
`endif
    end

    // registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_q <= 1'b0;
            oops_q  <= 1'b0;
            onoff_q <= 1'b0;
            login_q <= '0;
        end else begin
            enter_q <= enter_d;
            oops_q  <= oops_d;
            onoff_q <= onoff_d;
            login_q <= login_d;
        end
    end

    assign enter = enter_q;
    assign oops  = oops_q;
    assign onoff = onoff_q;
    assign login = login_q;

endmodule

// File: tb/tb_lock_input_cond.sv
// Bench for lock_input_cond: directed vector table, corner-case sequences and
// random stimulus against a sliding-window debounce model.
module tb_lock_input_cond;

    localparam int S   = 2;
    localparam int D   = 4;
    localparam int NSW = 4;
    localparam int NI  = NSW + 3;
`ifdef LOCK_LOGIN_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            btn_enter, btn_oops, sw_onoff;
    logic [NSW-1:0]  sw_login;
    logic            enter, oops, onoff;
    logic [NSW-1:0]  login;

    lock_input_cond #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .N_SW            (NSW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_enter (btn_enter),
        .btn_oops  (btn_oops),
        .sw_onoff  (sw_onoff),
        .sw_login  (sw_login),
        .enter     (enter),
        .oops      (oops),
        .onoff     (onoff),
        .login     (login)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_enter = 0, n_oops = 0;
    int last_enter_cyc = -1, last_oops_cyc = -1;
    bit seen_glitch = 1'b0;

    // Model: an input's accepted level flips when the last D synchronised
    // samples (raw delayed by S edges) all disagree with it; outputs lag by one edge.
    logic [S+D-1:0] m_hist [NI];
    logic [NI-1:0]  m_acc, m_lvl;
    logic           m_enter, m_oops;
    logic [NSW-1:0] m_login;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NI-1:0] raw, prev, rise;
        raw = {sw_login, sw_onoff, btn_oops, btn_enter};
        if (!reset) begin
            for (int i = 0; i < NI; i++) m_hist[i] = '0;
            m_acc = '0; m_lvl = '0; m_enter = 1'b0; m_oops = 1'b0; m_login = '0;
        end else begin
            prev  = m_lvl;
            m_lvl = m_acc;
            for (int i = 0; i < NI; i++) begin
                m_hist[i] = {m_hist[i][S+D-2:0], raw[i]};
                if (m_hist[i][S+D-1:S] == {D{~m_acc[i]}}) m_acc[i] = ~m_acc[i];
            end
            rise    = m_lvl & ~prev;
            m_oops  = rise[1];
            m_enter = rise[0] & ~rise[1];
            if (!LATCH || m_enter) m_login = m_lvl[NI-1:3];
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check1({tag, "_enter"}, 32'(enter), 32'(m_enter));
        check1({tag, "_oops"},  32'(oops),  32'(m_oops));
        check1({tag, "_onoff"}, 32'(onoff), 32'(m_onoff_w()));
        check1({tag, "_login"}, 32'(login), 32'(m_login));
        if (enter === 1'b1) begin n_enter++; last_enter_cyc = cyc; end
        if (oops === 1'b1)  begin n_oops++;  last_oops_cyc  = cyc; end
        if (login === 4'b1011) seen_glitch = 1'b1;
    endtask

    function automatic logic m_onoff_w();
        return m_lvl[2];
    endfunction

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    typedef struct {
        logic       rst, be, bo, on;
        logic [3:0] lg;
        int         n;
        logic       e_en, e_oo, e_on;
        logic [3:0] e_lg;
    } vec_t;

    vec_t tbl [13];
    logic [3:0] lat_lg;
    int t0;

    initial begin
        reset = 1'b0; btn_enter = 1'b0; btn_oops = 1'b0; sw_onoff = 1'b0; sw_login = 4'h0;
        lat_lg = LATCH ? 4'hF : 4'hA;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 3,  1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 6,  1'b0, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1,  1'b1, 1'b0, 1'b1, 4'hF};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1,  1'b0, 1'b0, 1'b1, 4'hF};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 8,  1'b0, 1'b0, 1'b1, 4'hF};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 10, 1'b0, 1'b0, 1'b1, 4'hF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 6,  1'b0, 1'b0, 1'b1, 4'hF};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1,  1'b0, 1'b0, 1'b0, 4'hF};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 7,  1'b0, 1'b0, 1'b0, lat_lg};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 6,  1'b0, 1'b0, 1'b0, lat_lg};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1,  1'b0, 1'b1, 1'b0, lat_lg};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1,  1'b0, 1'b0, 1'b0, lat_lg};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 10, 1'b0, 1'b0, 1'b0, lat_lg};

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; btn_enter = tbl[i].be; btn_oops = tbl[i].bo;
            sw_onoff = tbl[i].on; sw_login = tbl[i].lg;
            ticks(tbl[i].n, "vec");
            check1($sformatf("vec%0d_enter", i), 32'(enter), 32'(tbl[i].e_en));
            check1($sformatf("vec%0d_oops", i),  32'(oops),  32'(tbl[i].e_oo));
            check1($sformatf("vec%0d_onoff", i), 32'(onoff), 32'(tbl[i].e_on));
            check1($sformatf("vec%0d_login", i), 32'(login), 32'(tbl[i].e_lg));
        end

        // bouncing enter, then a solid hold: one pulse, 7 clk after the final rise
        n_enter = 0;
        btn_enter = 1'b1; tick("bnc"); btn_enter = 1'b0; tick("bnc");
        btn_enter = 1'b1; tick("bnc"); btn_enter = 1'b0; tick("bnc");
        btn_enter = 1'b1; t0 = cyc;
        ticks(20, "bnc");
        check1("bounce_pulses", 32'(n_enter), 32'd1);
        check1("bounce_latency", 32'(last_enter_cyc - t0), 32'd7);
        btn_enter = 1'b0; n_enter = 0;
        ticks(12, "rel");
        check1("release_pulses", 32'(n_enter), 32'd0);

        // short login glitch never reaches the output
        seen_glitch = 1'b0;
        ticks(8, "gl");
        sw_login = 4'b1011; ticks(2, "gl");
        sw_login = 4'b1010; ticks(12, "gl");
        check1("glitch_seen", 32'(seen_glitch), 32'd0);
        check1("glitch_login", 32'(login), 32'hA);

        // simultaneous presses: oops only
        n_enter = 0; n_oops = 0;
        btn_enter = 1'b1; btn_oops = 1'b1; ticks(12, "sim");
        check1("sim_oops", 32'(n_oops), 32'd1);
        check1("sim_enter", 32'(n_enter), 32'd0);
        btn_enter = 1'b0; btn_oops = 1'b0; ticks(12, "sim");
        check1("sim_oops_rel", 32'(n_oops), 32'd1);

        // reset during oops PRESS_WAIT, button kept held
        n_oops = 0;
        btn_oops = 1'b1; ticks(4, "rpw");
        reset = 1'b0; #1;
        check1("rst_async_enter", 32'(enter), 32'd0);
        check1("rst_async_oops",  32'(oops),  32'd0);
        check1("rst_async_onoff", 32'(onoff), 32'd0);
        check1("rst_async_login", 32'(login), 32'd0);
        ticks(2, "rpw");
        check1("rst_no_pulse", 32'(n_oops), 32'd0);
        reset = 1'b1; t0 = cyc;
        ticks(10, "rpw");
        check1("rst_one_pulse", 32'(n_oops), 32'd1);
        check1("rst_pulse_lat", 32'(last_oops_cyc - t0), 32'd7);
        btn_oops = 1'b0; ticks(10, "rpw");

        // login capture on enter (follows switches when latch disabled)
        sw_login = 4'hF; ticks(8, "lat");
        btn_enter = 1'b1; ticks(10, "lat");
        sw_login = 4'h1; ticks(12, "lat");
        check1("latch_hold", 32'(login), LATCH ? 32'hF : 32'h1);
        btn_enter = 1'b0; ticks(10, "lat");
        btn_enter = 1'b1; ticks(10, "lat");
        check1("latch_reload", 32'(login), 32'h1);
        btn_enter = 1'b0; ticks(8, "lat");

        // random stimulus with occasional resets
        for (int r = 0; r < 600; r++) begin
            if ($urandom_range(5) == 0) btn_enter = ~btn_enter;
            if ($urandom_range(5) == 0) btn_oops  = ~btn_oops;
            if ($urandom_range(5) == 0) sw_onoff  = ~sw_onoff;
            for (int b = 0; b < NSW; b++) begin
                if ($urandom_range(7) == 0) sw_login[b] = ~sw_login[b];
            end
            if (reset && $urandom_range(149) == 0) reset = 1'b0;
            else if (!reset && $urandom_range(2) == 0) reset = 1'b1;
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
